// File: rtl/msrv32_wb_mux_pipe_pkg.sv
// rtl/msrv32_wb_mux_pipe_pkg.sv - shared constants, wb source indices and skid state encoding
package msrv32_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RADDR_W  = 5;

    // Named writeback source slots; indices 6 and up are spare.
    localparam int WB_ALU    = 0;
    localparam int WB_LU     = 1;
    localparam int WB_IMM    = 2;
    localparam int WB_IADDER = 3;
    localparam int WB_CSR    = 4;
    localparam int WB_PC4    = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/msrv32_wb_mux_pipe_if.sv
// rtl/msrv32_wb_mux_pipe_if.sv - valid/ready writeback entry channel {data, rd, wr_en}
interface msrv32_wb_mux_pipe_if #(parameter int XLEN = 32);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            wr_en;

    modport master (output valid, data, rd, wr_en, input ready);
    modport slave  (input valid, data, rd, wr_en, output ready);
endinterface

// File: rtl/msrv32_wb_mux_pipe_skid_buf.sv
// rtl/msrv32_wb_mux_pipe_skid_buf.sv - 2-entry valid/ready skid buffer (main + skid register)
module msrv32_wb_skid_buf
    import msrv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    msrv32_wb_mux_pipe_if.slave    in_s,
    msrv32_wb_mux_pipe_if.master   out_m
);

    skid_state_e     state_q, state_d;
    logic [XLEN-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [4:0]      main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
    logic            main_we_q, main_we_d, skid_we_q, skid_we_d;
    logic            accept, xfer;

    assign in_s.ready  = (state_q != FULL);
    assign out_m.valid = (state_q != EMPTY);
    assign out_m.data  = main_data_q;
    assign out_m.rd    = main_rd_q;
    assign out_m.wr_en = main_we_q && (state_q != EMPTY);

    assign accept = in_s.valid && (state_q != FULL);
    assign xfer   = out_m.ready && (state_q != EMPTY);

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        main_we_d   = main_we_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_we_d   = skid_we_q;
        // Flush beats both accept and transfer; held data is left as-is.
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    main_data_d = in_s.data;
                    main_rd_d   = in_s.rd;
                    main_we_d   = in_s.wr_en;
                    state_d     = ONE;
                end
                ONE: begin
                    if (accept && xfer) begin
                        main_data_d = in_s.data;
                        main_rd_d   = in_s.rd;
                        main_we_d   = in_s.wr_en;
                    end else if (accept) begin
                        skid_data_d = in_s.data;
                        skid_rd_d   = in_s.rd;
                        skid_we_d   = in_s.wr_en;
                        state_d     = FULL;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (xfer) begin
                    main_data_d = skid_data_q;
                    main_rd_d   = skid_rd_q;
                    main_we_d   = skid_we_q;
                    state_d     = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_rd_q   <= '0;
            main_we_q   <= 1'b0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            skid_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            main_we_q   <= main_we_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            skid_we_q   <= skid_we_d;
        end
    end

endmodule

// File: rtl/msrv32_wb_mux_pipe.sv
// rtl/msrv32_wb_mux_pipe.sv - registered writeback select with skid buffer; MSRV32_WB_FWD_EN adds bypass outputs
module msrv32_wb_mux_pipe
    import msrv32_pkg::*;
#(
    parameter  int XLEN    = XLEN_DEF,
    parameter  int NUM_SRC = 8,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                    ms_riscv32_mp_clk_in,
    input  logic                    ms_riscv32_mp_rst_n_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [SEL_W-1:0]        wb_mux_sel_in,
    input  logic [NUM_SRC*XLEN-1:0] src_data_in,
    input  logic [RADDR_W-1:0]      rd_addr_in,
    input  logic                    rf_wr_en_in,
    input  logic                    alu_src_in,
    input  logic [XLEN-1:0]         imm_in,
    input  logic [XLEN-1:0]         rs2_in,
    input  logic                    flush_in,
    input  logic                    wb_ready_in,
    output logic                    wb_valid_out,
    output logic [XLEN-1:0]         wb_data_out,
    output logic [RADDR_W-1:0]      wb_rd_out,
    output logic                    wb_wr_en_out,
    output logic [XLEN-1:0]         alu_2nd_src_out,
    output logic                    illegal_sel_out,
    output logic                    fwd_valid_out,
    output logic [RADDR_W-1:0]      fwd_rd_out,
    output logic [XLEN-1:0]         fwd_data_out
);

    msrv32_wb_mux_pipe_if #(.XLEN(XLEN)) up_if ();
    msrv32_wb_mux_pipe_if #(.XLEN(XLEN)) dn_if ();

    logic [XLEN-1:0] sel_data;
    logic            sel_hit;
    logic            illegal_q, illegal_d;

    // A select that matches no source yields zero data and no write.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (wb_mux_sel_in == SEL_W'(k)) begin
                sel_data = src_data_in[k*XLEN +: XLEN];
                sel_hit  = 1'b1;
            end
        end
    end

    assign up_if.valid = valid_in;
    assign up_if.data  = sel_data;
    assign up_if.rd    = rd_addr_in;
    assign up_if.wr_en = rf_wr_en_in && sel_hit && (rd_addr_in != '0);
    assign ready_out   = up_if.ready;

    assign dn_if.ready   = wb_ready_in;
    assign wb_valid_out  = dn_if.valid;
    assign wb_data_out   = dn_if.data;
    assign wb_rd_out     = dn_if.rd;
    assign wb_wr_en_out  = dn_if.wr_en;

    assign alu_2nd_src_out = alu_src_in ? imm_in : rs2_in;

    always_comb begin
        illegal_d = illegal_q | (valid_in && ready_out && !flush_in && !sel_hit);
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) illegal_q <= 1'b0;
        else                         illegal_q <= illegal_d;
    end

    assign illegal_sel_out = illegal_q;

    msrv32_wb_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk_i   (ms_riscv32_mp_clk_in),
        .rst_n_i (ms_riscv32_mp_rst_n_in),
        .flush_i (flush_in),
        .in_s    (up_if),
        .out_m   (dn_if)
    );

`ifdef MSRV32_WB_FWD_EN
    assign fwd_valid_out = wb_valid_out && wb_wr_en_out;
    assign fwd_rd_out    = wb_rd_out;
    assign fwd_data_out  = wb_data_out;
`else
    assign fwd_valid_out = 1'b0;
    assign fwd_rd_out    = '0;
    assign fwd_data_out  = '0;
`endif

endmodule

// File: doc/msrv32_wb_mux_pipe.md
Name: msrv32_wb_mux_pipe

Overview:
Parametrised, registered successor to the combinational writeback select unit of the msrv32 core. It selects one of NUM_SRC writeback sources and registers the result with rd address and write-enable. It also drives the ALU second-operand mux. It adds a valid/ready handshake, a 2-entry skid buffer, flush, x0 write suppression and illegal-select detection, so the core can stall writeback without losing results.

Parameters:
XLEN, 32, datapath width of every source and of the result
NUM_SRC, 8, number of writeback sources; must be 2..16
SEL_W, $clog2(NUM_SRC), select width (localparam, derived)

Ports:
ms_riscv32_mp_clk_in  in  1  core clock
ms_riscv32_mp_rst_n_in  in  1  asynchronous active-low reset
valid_in  in  1  upstream result valid
ready_out  out  1  block can accept; equals !skid_full
wb_mux_sel_in  in  SEL_W  source index
src_data_in  in  NUM_SRC*XLEN  flattened sources; source k = bits [k*XLEN +: XLEN]
rd_addr_in  in  5  destination register
rf_wr_en_in  in  1  instruction writes the register file
alu_src_in  in  1  1 = immediate, 0 = rs2
imm_in  in  XLEN  immediate
rs2_in  in  XLEN  rs2 value
flush_in  in  1  synchronous pipeline flush
wb_ready_in  in  1  downstream accepts
wb_valid_out  out  1  registered result valid
wb_data_out  out  XLEN  registered selected data
wb_rd_out  out  5  registered rd
wb_wr_en_out  out  1  registered write-enable; gated by valid
alu_2nd_src_out  out  XLEN  combinational: imm_in if alu_src_in, else rs2_in
illegal_sel_out  out  1  sticky flag; set when an accepted sel >= NUM_SRC
fwd_valid_out  out  1  forward path valid (see Optional Feature)
fwd_rd_out  out  5  forward rd
fwd_data_out  out  XLEN  forward data

Behaviour:
- Reset: all registers and outputs 0, except alu_2nd_src_out (combinational); ready_out=1 after reset.
- Accept: valid_in && ready_out at the clock edge. Transfer out: wb_valid_out && wb_ready_in.
- Latency: 1 cycle from accept to wb_valid_out when the main register is empty or draining.
- Select: selected data = source[sel]. If sel >= NUM_SRC: data = 0, write-enable forced to 0, illegal_sel_out set to 1. Only reset clears it.
- x0 rule: rd_addr_in==0 forces the stored wr_en to 0; data is still stored.
- Storage: main register (drives outputs) plus one skid register.
  - States: EMPTY (main empty), ONE (main full, skid empty), FULL (both full).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept and transfer out -> ONE; main takes the new entry.
    - accept, no transfer out -> FULL; new entry goes to skid.
    - transfer out only -> EMPTY.
  - FULL: ready_out=0, no accept. Transfer out -> ONE; skid moves to main.
- Order is strictly preserved; no entry is dropped or duplicated.
- wb_wr_en_out = stored wr_en && wb_valid_out.
- flush_in: next edge -> EMPTY, both entries invalidated. Flush wins over a simultaneous accept (input dropped) and over a transfer out. ready_out=1 the cycle after.
- Asynchronous reset mid-operation clears state immediately; no handshake is required.
- Output data registers hold their value when invalid; only the valid and wr_en outputs are gated.

Optional Feature:
Macro MSRV32_WB_FWD_EN.
- Defined: fwd_valid_out = wb_valid_out && wb_wr_en_out; fwd_rd_out = wb_rd_out; fwd_data_out = wb_data_out. This gives the decode stage a bypass source for the pending write.
- Undefined: fwd_valid_out, fwd_rd_out and fwd_data_out are tied to 0; no extra logic.

Decomposition:
- Package msrv32_pkg: XLEN default, register-address width 5, and named wb source indices. WB_ALU=0, WB_LU=1, WB_IMM=2, WB_IADDER=3, WB_CSR=4, WB_PC4=5, remaining slots spare. Also the state encoding EMPTY/ONE/FULL.
- Sub-module msrv32_wb_skid_buf: a generic 2-entry valid/ready skid holding {data, rd, wr_en}. Top level = select/illegal logic + skid buffer + ALU operand mux.

Test Plan:
- Reset: rst_n=0 mid-stream with FULL state -> all outputs 0 at once; after release ready_out=1, wb_valid_out=0.
- Select sweep: source k = 32'h1000_0000+k, wb_ready_in=1, sel=0..5 back-to-back, rd=5'd3, wr_en=1 -> wb_data_out = 32'h1000_0000..5 one cycle after each accept, wb_wr_en_out=1. Also alu_src 0/1 with rs2=32'h11223344, imm=32'h0000FFFF -> alu_2nd_src_out follows combinationally.
- Backpressure: wb_ready_in=0, send A=32'hA, B=32'hB -> ready_out=0 after B. Raise wb_ready_in -> A then B out in order, ready_out=1 again.
- Boundary: NUM_SRC=6, sel=3'd7 -> wb_data_out=0, wb_wr_en_out=0, illegal_sel_out=1 and it stays set. Separately, rd=0 with wr_en=1 -> wb_wr_en_out=0.
- Flush: in FULL state assert flush_in together with valid_in -> next cycle wb_valid_out=0, ready_out=1; the flushed and incoming entries never appear.
- Forwarding, with MSRV32_WB_FWD_EN defined: accept rd=5'd7, data=32'hDEADBEEF -> fwd_valid_out=1, fwd_rd_out=7, fwd_data_out=32'hDEADBEEF. With the macro undefined, the forward ports stay 0.
